regfile_2w2r: RTL and testbench
===============================

Name: regfile_2w2r

Overview:
- Parametrised successor to the single-port CPU register bank.
- Two registered read ports and two write ports, with same-cycle write-to-read bypass and a deterministic write-collision rule.
- A sequential soft-clear engine zeroes the file one entry per cycle.
- Sits between decode (read) and writeback (two retire lanes) of the MIPS32 datapath.
- Also drives the 16-bit board debug display.

Parameters:
- DATA_W, 32, register width in bits (must be >= 8).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (internal localparam).
- DBG_LO, 3, register index whose [7:0] drives dbg_out[7:0].
- DBG_HI, 4, register index whose [7:0] drives dbg_out[15:8].

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_all  in  1  synchronous, active-high reset.
- enable  in  1  global qualifier for reads, writes and clear progress.
- rd_en  in  1  read strobe for both read ports.
- rs  in  ADDR_W  read port 1 address.
- rt  in  ADDR_W  read port 2 address.
- out1  out  DATA_W  read port 1 data (registered).
- out2  out  DATA_W  read port 2 data (registered).
- we0  in  1  write lane 0 enable.
- wa0  in  ADDR_W  write lane 0 address.
- wd0  in  DATA_W  write lane 0 data.
- we1  in  1  write lane 1 enable.
- wa1  in  ADDR_W  write lane 1 address.
- wd1  in  DATA_W  write lane 1 data.
- clr_req  in  1  soft-clear request pulse.
- clr_busy  out  1  high while soft-clear is running.
- dbg_out  out  16  {R[DBG_HI][7:0], R[DBG_LO][7:0]}, combinational from storage.

Behaviour:
- Reset (posedge with reset_all=1): all DEPTH entries, out1, out2 = 0; FSM -> IDLE; clr_busy = 0; clear pointer = 0. reset_all overrides every other input. Reset during CLEAR aborts the clear.
- Writes: performed at posedge when enable && weN && !clr_busy.
  - Both lanes to the same address: lane 1 wins; lane 0 is dropped.
  - Different addresses: both commit in the same cycle.
- Reads: at posedge when enable && rd_en, out1/out2 load the selected value; otherwise they hold. Latency is 1 cycle from address to data.
- Bypass priority for each read port: lane 1 write to the same address (if that write is accepted), then lane 0 write to the same address (if accepted), then stored R[addr]. Read data therefore equals the post-write value of that cycle.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR at posedge when enable && clr_req; pointer := 0. Writes in that same cycle still commit, then get cleared.
  - In CLEAR with enable=1: R[pointer] := 0 and pointer increments; when pointer == DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
  - In CLEAR with enable=0: FSM and pointer hold.
  - clr_req while in CLEAR is ignored (no restart).
- clr_busy is high exactly while in CLEAR: DEPTH enabled cycles, starting the cycle after the request.
- Writes during CLEAR are dropped silently. Reads during CLEAR are allowed and return current storage, i.e. the old value for the entry being cleared that cycle.
- dbg_out follows storage immediately after any write, clear step or reset.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined:
  - Entry 0 is hardwired to zero and writes to address 0 on either lane are discarded.
  - Reads of address 0 return 0 and bypass to address 0 is suppressed.
  - If lane 1 targets address 0 and lane 0 targets the same address, the lane 0 write is also discarded; no fallback to lane 0.
  - The clear engine still walks all DEPTH entries, so timing is unchanged.
- When undefined: entry 0 is an ordinary register.

Test Plan:
- Reset: preload R[5]=0xDEADBEEF, pulse reset_all for 1 cycle -> next cycle reading rs=5 gives out1=0; dbg_out=0x0000; clr_busy=0.
- Write/read latency: cycle N we0=1, wa0=3, wd0=0x000000A5, rd_en=0; cycle N+1 rs=3, rd_en=1 -> out1=0x000000A5 after the N+1 edge; dbg_out[7:0]=0xA5 from the cycle after N.
- Collision plus bypass: same cycle we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22, rd_en=1, rs=rt=7 -> out1=out2=0x22; a later read of 7 returns 0x22.
- Dual write / dual read: wa0=1, wd0=0x100 and wa1=2, wd1=0x200 in one cycle; next cycle rs=1, rt=2 -> out1=0x100, out2=0x200.
- Soft clear: fill all 16 entries with nonzero data, pulse clr_req; we1=1 to addr 9 mid-clear; enable=0 for 3 cycles mid-clear.
  - clr_busy is high for exactly 16 enabled cycles (19 cycles total) and the write to 9 is dropped.
  - All entries read 0 afterwards.
  - Repeat with reset_all asserted mid-clear -> FSM returns to IDLE and all entries are 0 immediately.
- With REGFILE_ZERO_REG_EN: we1=1, wa1=0, wd1=0xFFFFFFFF with rs=0, rd_en=1 -> out1=0 both in the write cycle and on later reads.

Source files
------------

// File: rtl/regfile_2w2r.sv
// -----------------------------------------------------------------------------
// regfile_2w2r
//   Register file with two registered read ports and two write lanes, placed
//   between decode (reads) and the two writeback retire lanes of the MIPS32
//   datapath. A sequential soft-clear engine zeroes one entry per enabled
//   cycle. Two selected entries also drive the 16-bit board debug display.
//
//   Optional build macro: REGFILE_ZERO_REG_EN
//     defined   -> entry 0 is hardwired to zero; writes to address 0 are
//                  discarded and reads of address 0 return zero.
//     undefined -> entry 0 is an ordinary register.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset_all  in   synchronous active-high reset, overrides every input
//   enable     in   global qualifier for reads, writes and clear progress
//   rd_en      in   read strobe shared by both read ports
//   rs, rt     in   read addresses for port 1 / port 2
//   out1, out2 out  registered read data, one cycle after the address
//   we0/wa0/wd0 in  write lane 0 enable / address / data
//   we1/wa1/wd1 in  write lane 1 enable / address / data (wins collisions)
//   clr_req    in   soft-clear request pulse
//   clr_busy   out  high while the soft-clear engine runs
//   dbg_out    out  {R[DBG_HI][7:0], R[DBG_LO][7:0]}, straight from storage
//
// Clear FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | normal operation; writes accepted; waits for clr_req
//   ST_CLEAR | zeroes R[ptr] each enabled cycle; writes dropped; exits
//            | after the last entry (DEPTH enabled cycles in total)
// -----------------------------------------------------------------------------
module regfile_2w2r #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DBG_LO = 3,
  parameter int DBG_HI = 4
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic              enable,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [15:0]       dbg_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              clr_busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;

  logic wr_open;
  logic lane0_ok;
  logic acc0;
  logic acc1;
  logic clr_step;

  // ---------------------------------------------------------------------------
  // Clear FSM. clr_busy is a registered copy of (state_q == ST_CLEAR) so the
  // output comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      clr_busy_q <= 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr_req is ignored here: a running clear is never restarted.
          if (ptr_q == CLR_LAST) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ptr_q      <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_step = enable && (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Write acceptance. Writes are only taken outside a clear. When both lanes
  // target the same address lane 1 wins. With the zero register, a lane 1
  // write to address 0 is discarded and lane 0 gets no fallback because lane
  // 0 to address 0 is itself discarded.
  // ---------------------------------------------------------------------------
  assign wr_open = enable && !clr_busy_q;

`ifdef REGFILE_ZERO_REG_EN
  assign acc1     = wr_open && we1 && (wa1 != '0);
  assign lane0_ok = wr_open && we0 && (wa0 != '0);
`else
  assign acc1     = wr_open && we1;
  assign lane0_ok = wr_open && we0;
`endif

  assign acc0 = lane0_ok && !(acc1 && (wa1 == wa0));

  // ---------------------------------------------------------------------------
  // Storage next state. Writes and clear steps are mutually exclusive since
  // writes are closed while clearing.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (acc0) begin
      mem_d[wa0] = wd0;
    end
    if (acc1) begin
      mem_d[wa1] = wd1;
    end
    if (clr_step) begin
      mem_d[ptr_q] = '0;
    end
`ifdef REGFILE_ZERO_REG_EN
    mem_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-to-read bypass: lane 1, then lane 0, then storage.
  // A clear step is deliberately not bypassed, so a read of the entry being
  // cleared returns its old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    out1_d = mem_q[rs];
    if (acc0 && (wa0 == rs)) begin
      out1_d = wd0;
    end
    if (acc1 && (wa1 == rs)) begin
      out1_d = wd1;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (rs == '0) begin
      out1_d = '0;
    end
`endif
  end

  always_comb begin
    out2_d = mem_q[rt];
    if (acc0 && (wa0 == rt)) begin
      out2_d = wd0;
    end
    if (acc1 && (wa1 == rt)) begin
      out2_d = wd1;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (rt == '0) begin
      out2_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      out1_q <= '0;
      out2_q <= '0;
    end else if (enable && rd_en) begin
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out1     = out1_q;
  assign out2     = out2_q;
  assign clr_busy = clr_busy_q;
  assign dbg_out  = {mem_q[DBG_HI][7:0], mem_q[DBG_LO][7:0]};

endmodule

// File: tb/tb_regfile_2w2r.sv
// -----------------------------------------------------------------------------
// tb_regfile_2w2r
//   Directed bench for regfile_2w2r. Stimulus pushes the expected read data
//   into a queue whenever it issues an enabled read; a monitor pops and
//   compares one cycle later when the read data is presented.
// -----------------------------------------------------------------------------
module tb_regfile_2w2r;

  localparam int DW = 32;
  localparam int AW = 4;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] ZR_EXP = 32'h0000_0000;
  localparam logic [31:0] E0_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] ZR_EXP = 32'hFFFF_FFFF;
  localparam logic [31:0] E0_EXP = 32'h0000_1000;
`endif

  logic          clk = 1'b0;
  logic          reset_all;
  logic          enable;
  logic          rd_en;
  logic [AW-1:0] rs, rt;
  logic [DW-1:0] out1, out2;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic          clr_req;
  logic          clr_busy;
  logic [15:0]   dbg_out;

  int errors = 0;
  int checks = 0;
  int busy_cnt;

  logic [63:0] exp_q [$];
  string       name_q [$];
  logic        mon_fire;

  always #5 clk = ~clk;

  regfile_2w2r #(
    .DATA_W(DW), .ADDR_W(AW), .DBG_LO(3), .DBG_HI(4)
  ) dut (
    .clk(clk), .reset_all(reset_all), .enable(enable), .rd_en(rd_en),
    .rs(rs), .rt(rt), .out1(out1), .out2(out2),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(clr_busy), .dbg_out(dbg_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a read is presented one cycle after an enabled rd_en edge.
  always @(posedge clk) begin
    mon_fire = enable && rd_en && !reset_all;
    #1;
    if (mon_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got out1=0x%08h out2=0x%08h expected no read", out1, out2);
      end else begin
        logic [63:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_out1"}, out1, e[63:32]);
        check({nm, "_out2"}, out2, e[31:0]);
      end
    end
  end

  task automatic idle_inputs();
    reset_all = 1'b0;
    enable    = 1'b1;
    rd_en     = 1'b0;
    rs = '0; rt = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    clr_req   = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic w0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we0 = 1'b1; wa0 = a; wd0 = d;
  endtask

  task automatic w1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we1 = 1'b1; wa1 = a; wd1 = d;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2, input string nm);
    rd_en = 1'b1; rs = a1; rt = a2;
    exp_q.push_back({e1, e2});
    name_q.push_back(nm);
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) begin
      w0(AW'(2 * i), 32'h1000 + 32'(2 * i));
      w1(AW'(2 * i + 1), 32'h1000 + 32'(2 * i + 1));
      cyc();
    end
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < 8; i++) begin
      rd(AW'(2 * i), AW'(2 * i + 1), 32'h0, 32'h0, nm);
      cyc();
    end
  endtask

  initial begin
    idle_inputs();
    reset_all = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();

    // Reset state
    check("rst_busy", 32'(clr_busy), 32'h0);
    check("rst_dbg", {16'h0, dbg_out}, 32'h0);
    rd(4'd0, 4'd15, 32'h0, 32'h0, "rst_rd");
    cyc();

    // Preload, then reset clears it
    w0(4'd5, 32'hDEADBEEF);
    cyc();
    rd(4'd5, 4'd0, 32'hDEADBEEF, 32'h0, "pre_rst");
    cyc();
    reset_all = 1'b1;
    cyc();
    check("post_rst_busy", 32'(clr_busy), 32'h0);
    check("post_rst_dbg", {16'h0, dbg_out}, 32'h0);
    rd(4'd5, 4'd5, 32'h0, 32'h0, "post_rst");
    cyc();

    // Write then read one cycle later
    w0(4'd3, 32'h0000_00A5);
    cyc();
    check("lat_dbg", {16'h0, dbg_out}, 32'h0000_00A5);
    rd(4'd3, 4'd4, 32'h0000_00A5, 32'h0, "lat_rd");
    cyc();
    rs = 4'd7;
    cyc();
    check("hold_out1", out1, 32'h0000_00A5);

    // Lane collision with bypass on both ports
    w0(4'd7, 32'h11);
    w1(4'd7, 32'h22);
    rd(4'd7, 4'd7, 32'h22, 32'h22, "coll_byp");
    cyc();
    rd(4'd7, 4'd7, 32'h22, 32'h22, "coll_later");
    cyc();

    // Lane 0 bypass alone
    w0(4'd4, 32'h5A);
    rd(4'd4, 4'd3, 32'h5A, 32'hA5, "byp0");
    cyc();
    check("dbg_both", {16'h0, dbg_out}, 32'h0000_5AA5);

    // Dual write, dual read
    w0(4'd1, 32'h100);
    w1(4'd2, 32'h200);
    cyc();
    rd(4'd1, 4'd2, 32'h100, 32'h200, "dual");
    cyc();

    // Each port bypasses from a different lane
    w0(4'd8, 32'h800);
    w1(4'd9, 32'h900);
    rd(4'd9, 4'd8, 32'h900, 32'h800, "byp_mix");
    cyc();

    // enable low blocks both the write and the read
    enable = 1'b0;
    w0(4'd10, 32'hBAD);
    rd_en = 1'b1;
    rs = 4'd10;
    cyc();
    check("en_off_hold", out1, 32'h900);
    rd(4'd10, 4'd1, 32'h0, 32'h100, "en_off");
    cyc();

    // Address 0 writes (zero register when the macro is defined)
    w0(4'd0, 32'h1234);
    w1(4'd0, 32'hFFFF_FFFF);
    rd(4'd0, 4'd0, ZR_EXP, ZR_EXP, "zr_byp");
    cyc();
    rd(4'd0, 4'd0, ZR_EXP, ZR_EXP, "zr_later");
    cyc();

    // Soft clear with a dropped write, a restart attempt and a stall
    fill_all();
    rd(4'd0, 4'd15, E0_EXP, 32'h100F, "fill");
    cyc();
    clr_req = 1'b1;
    cyc();
    busy_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (!clr_busy) break;
      busy_cnt++;
      enable = !(t >= 9 && t <= 11);
      if (t == 2) clr_req = 1'b1;
      if (t == 5) w1(4'd9, 32'h9999);
      if (t == 6) rd(4'd6, 4'd0, 32'h1006, 32'h0, "clr_cur");
      if (t == 8) rd(4'd9, 4'd7, 32'h1009, 32'h0, "clr_drop");
      cyc();
    end
    check("clr_cycles", 32'(busy_cnt), 32'd19);
    check("clr_dbg", {16'h0, dbg_out}, 32'h0);
    read_all_zero("clr_zero");
    w0(4'd4, 32'h77);
    cyc();
    rd(4'd4, 4'd4, 32'h77, 32'h77, "post_clr");
    cyc();
    check("post_clr_dbg", {16'h0, dbg_out}, 32'h0000_7700);

    // Reset aborts a running clear
    fill_all();
    clr_req = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) cyc();
    check("clr2_busy", 32'(clr_busy), 32'h1);
    reset_all = 1'b1;
    cyc();
    check("abort_busy", 32'(clr_busy), 32'h0);
    check("abort_dbg", {16'h0, dbg_out}, 32'h0);
    read_all_zero("abort_zero");

    cyc();
    cyc();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
